fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch sequencer.
// Steps through memory request, predictor lookup and instruction-queue push.
// Also handles JALR stalls, where the target is resolved late, and ROB
// flush redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  // instruction memory
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_instr,
  // branch predictor
  output logic        pred_ask,
  output logic [31:0] pred_pc,
  output logic [31:0] pred_instr,
  input  logic        pred_enable,
  input  logic        pred_stall,
  input  logic        pred_taken,
  input  logic [31:0] pred_next_pc,
  // instruction queue push
  output logic        iq_valid,
  input  logic        iq_ready,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  output logic        iq_pred_taken,
  output logic [31:0] iq_pred_pc,
  // ROB redirect
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  typedef enum logic [2:0] {IDLE, FETCH, PRED, PUSH, JALR, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic        jalr_wait;
  logic        pending_vld;
  logic [31:0] pred_pending_pc;

  logic resolve;
  logic hs;

  // A JALR resolution is an enabled predictor cycle that is no longer stalling.
  assign resolve  = pred_enable & ~pred_stall;
  assign hs       = iq_valid & iq_ready;
  assign mem_req  = (state == FETCH);
  assign mem_addr = (state == FETCH) ? pc : 32'h0;

  // State register; rdy=0 freezes the machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= IDLE;
    else if (rdy) state <= state_nx;
  end

  // Next-state selection; flush overrides everything.
  always_comb begin
    state_nx = state;
    if (flush) begin
      // A request still in flight must be drained before refetching.
      if ((state == FETCH && !mem_done) || state == DRAIN) state_nx = DRAIN;
      else                                                 state_nx = FETCH;
    end else begin
      case (state)
        IDLE:  state_nx = FETCH;
        FETCH: if (mem_done) state_nx = PRED;
        PRED:  if (pred_enable) state_nx = PUSH;
        PUSH:  if (hs) state_nx = (!jalr_wait || pending_vld || resolve) ? FETCH : JALR;
        JALR:  if (resolve) state_nx = FETCH;
        DRAIN: if (mem_done) state_nx = FETCH;
        default: state_nx = IDLE;
      endcase
    end
  end

  // PC, predictor request, queue payload and JALR bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc              <= RESET_PC;
      pred_ask        <= 1'b0;
      pred_pc         <= 32'h0;
      pred_instr      <= 32'h0;
      iq_valid        <= 1'b0;
      iq_instr        <= 32'h0;
      iq_pc           <= 32'h0;
      iq_pred_taken   <= 1'b0;
      iq_pred_pc      <= 32'h0;
      jalr_wait       <= 1'b0;
      pending_vld     <= 1'b0;
      pred_pending_pc <= 32'h0;
    end else if (rdy) begin
      if (flush) begin
        pc              <= flush_pc;
        pred_ask        <= 1'b0;
        iq_valid        <= 1'b0;
        jalr_wait       <= 1'b0;
        pending_vld     <= 1'b0;
        pred_pending_pc <= 32'h0;
      end else begin
        pred_ask <= 1'b0;
        case (state)
          FETCH: if (mem_done) begin
            // pred_instr doubles as the latched instruction word.
            pred_ask   <= 1'b1;
            pred_pc    <= pc;
            pred_instr <= mem_instr;
          end
          PRED: if (pred_enable) begin
            iq_valid      <= 1'b1;
            iq_instr      <= pred_instr;
            iq_pc         <= pc;
            iq_pred_taken <= pred_taken;
            iq_pred_pc    <= pred_next_pc;
            jalr_wait     <= pred_stall;
          end
          PUSH: begin
            if (hs) begin
              iq_valid    <= 1'b0;
              jalr_wait   <= 1'b0;
              pending_vld <= 1'b0;
              if (!jalr_wait)       pc <= iq_pred_pc;
              else if (pending_vld) pc <= pred_pending_pc;
              else if (resolve)     pc <= pred_next_pc;
            end else if (jalr_wait && resolve && !pending_vld) begin
              // Early resolution while the queue is still back-pressuring.
              pending_vld     <= 1'b1;
              pred_pending_pc <= pred_next_pc;
            end
          end
          JALR: if (resolve) pc <= pred_next_pc;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic.
// Checks against a transaction-level model of the fetch loop.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_instr = 32'h0;
  logic        pred_ask;
  logic [31:0] pred_pc, pred_instr;
  logic        pred_enable = 1'b0, pred_stall = 1'b0, pred_taken = 1'b0;
  logic [31:0] pred_next_pc = 32'h0;
  logic        iq_valid;
  logic        iq_ready = 1'b0;
  logic [31:0] iq_instr, iq_pc, iq_pred_pc;
  logic        iq_pred_taken;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_instr(mem_instr),
    .pred_ask(pred_ask), .pred_pc(pred_pc), .pred_instr(pred_instr),
    .pred_enable(pred_enable), .pred_stall(pred_stall), .pred_taken(pred_taken),
    .pred_next_pc(pred_next_pc),
    .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_instr(iq_instr), .iq_pc(iq_pc),
    .iq_pred_taken(iq_pred_taken), .iq_pred_pc(iq_pred_pc),
    .flush(flush), .flush_pc(flush_pc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: where the single instruction in flight currently is.
  localparam int S_IDLE = 0, S_FET = 1, S_ASK = 2, S_WPR = 3, S_PSH = 4, S_JW = 5, S_DRN = 6;
  int          stg = S_IDLE;
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_npc = 32'h0, m_pend_pc = 32'h0;
  logic        m_taken = 1'b0, m_jw = 1'b0, m_pend = 1'b0;

  // Advance the model with the inputs the DUT sees on this edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg    <= S_IDLE;
      m_pc   <= 32'h0;
      m_jw   <= 1'b0;
      m_pend <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        m_pc   <= flush_pc;
        m_jw   <= 1'b0;
        m_pend <= 1'b0;
        stg    <= ((stg == S_FET && !mem_done) || stg == S_DRN) ? S_DRN : S_FET;
      end else begin
        case (stg)
          S_IDLE: stg <= S_FET;
          S_FET:  if (mem_done) begin m_instr <= mem_instr; stg <= S_ASK; end
          S_ASK:  stg <= S_WPR;
          S_WPR:  if (pred_enable) begin
            m_taken <= pred_taken; m_npc <= pred_next_pc; m_jw <= pred_stall; stg <= S_PSH;
          end
          S_PSH: begin
            if (iq_ready) begin
              m_pend <= 1'b0;
              m_jw   <= 1'b0;
              if (!m_jw)                          begin m_pc <= m_npc;        stg <= S_FET; end
              else if (m_pend)                    begin m_pc <= m_pend_pc;    stg <= S_FET; end
              else if (pred_enable && !pred_stall) begin m_pc <= pred_next_pc; stg <= S_FET; end
              else                                stg <= S_JW;
            end else if (m_jw && !m_pend && pred_enable && !pred_stall) begin
              m_pend <= 1'b1; m_pend_pc <= pred_next_pc;
            end
          end
          S_JW:  if (pred_enable && !pred_stall) begin m_pc <= pred_next_pc; stg <= S_FET; end
          S_DRN: if (mem_done) stg <= S_FET;
          default: stg <= S_IDLE;
        endcase
      end
    end
  end

  // Per-cycle compare of every meaningful output against the model.
  always @(negedge clk) begin
    chk("mem_req", 32'(mem_req), 32'(stg == S_FET));
    if (stg == S_FET) chk("mem_addr", mem_addr, m_pc);
    chk("pred_ask", 32'(pred_ask), 32'(stg == S_ASK));
    if (stg == S_ASK) begin
      chk("pred_pc", pred_pc, m_pc);
      chk("pred_instr", pred_instr, m_instr);
    end
    chk("iq_valid", 32'(iq_valid), 32'(stg == S_PSH));
    if (stg == S_PSH) begin
      chk("iq_pc", iq_pc, m_pc);
      chk("iq_instr", iq_instr, m_instr);
      chk("iq_pred_taken", 32'(iq_pred_taken), 32'(m_taken));
      chk("iq_pred_pc", iq_pred_pc, m_npc);
    end
  end

  task automatic tick();
    @(negedge clk);
    mem_done    = 1'b0;
    pred_enable = 1'b0;
    pred_stall  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin tick(); n++; end
    chk("wait_fetch", 32'(mem_req), 32'd1);
  endtask

  // From a FETCH sample: return the word, let pred_ask pass, then predict.
  // Returns sampling the PUSH cycle.
  task automatic fetch_one(input logic [31:0] ins, input logic tk,
                           input logic [31:0] npc, input logic st);
    mem_done = 1'b1; mem_instr = ins;
    tick();
    tick();
    pred_enable = 1'b1; pred_taken = tk; pred_next_pc = npc; pred_stall = st;
    tick();
  endtask

  initial begin
    // Reset values
    rst = 1'b0; rdy = 1'b1; iq_ready = 1'b1;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_pred_ask", 32'(pred_ask), 32'd0);
    chk("rst_iq_valid", 32'(iq_valid), 32'd0);
    chk("rst_iq_pc", iq_pc, 32'h0);
    chk("rst_iq_pred_pc", iq_pred_pc, 32'h0);
    chk("rst_pred_instr", pred_instr, 32'h0);
    rst = 1'b1;

    // Sequential fetch, minimum-latency loop
    wait_fetch();
    chk("seq_addr0", mem_addr, 32'h0);
    mem_done = 1'b1; mem_instr = 32'h0000_0013;
    tick();
    chk("seq_ask", 32'(pred_ask), 32'd1);
    chk("seq_ask_instr", pred_instr, 32'h0000_0013);
    tick();
    chk("seq_ask_once", 32'(pred_ask), 32'd0);
    pred_enable = 1'b1; pred_taken = 1'b0; pred_next_pc = 32'h4;
    tick();
    chk("seq_iq_pc", iq_pc, 32'h0);
    chk("seq_iq_instr", iq_instr, 32'h0000_0013);
    tick();
    chk("seq_next_req", 32'(mem_req), 32'd1);
    chk("seq_next_addr", mem_addr, 32'h4);

    // Backpressure for 5 cycles
    iq_ready = 1'b0;
    fetch_one(32'h00a0_0093, 1'b0, 32'h8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(iq_valid), 32'd1);
      chk("bp_no_req", 32'(mem_req), 32'd0);
      chk("bp_iq_pc", iq_pc, 32'h4);
      chk("bp_iq_instr", iq_instr, 32'h00a0_0093);
      tick();
    end
    iq_ready = 1'b1;
    tick();
    chk("bp_fetch_addr", mem_addr, 32'h8);
    chk("bp_valid_clr", 32'(iq_valid), 32'd0);

    // Taken branch at 0x100
    fetch_one(32'h1000_006f, 1'b1, 32'h100, 1'b0);
    tick();
    chk("br_addr100", mem_addr, 32'h100);
    fetch_one(32'hFE00_0EE3, 1'b1, 32'hFC, 1'b0);
    chk("br_taken", 32'(iq_pred_taken), 32'd1);
    chk("br_pred_pc", iq_pred_pc, 32'hFC);
    tick();
    chk("br_addr_fc", mem_addr, 32'hFC);

    // JALR with 7-cycle stall
    fetch_one(32'h0000_0013, 1'b0, 32'h20, 1'b0);
    tick();
    chk("jr_addr20", mem_addr, 32'h20);
    fetch_one(32'h0000_80E7, 1'b0, 32'h24, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("jr_no_req", 32'(mem_req), 32'd0);
      if (i % 2 == 1) begin pred_enable = 1'b1; pred_stall = 1'b1; end
      tick();
    end
    pred_enable = 1'b1; pred_stall = 1'b0; pred_next_pc = 32'h80;
    tick();
    chk("jr_addr80", mem_addr, 32'h80);

    // Early JALR resolution during PUSH
    iq_ready = 1'b0;
    fetch_one(32'h0000_80E7, 1'b0, 32'h84, 1'b1);
    pred_enable = 1'b1; pred_stall = 1'b0; pred_next_pc = 32'h300;
    tick();
    tick();
    chk("ej_hold_valid", 32'(iq_valid), 32'd1);
    chk("ej_no_req", 32'(mem_req), 32'd0);
    iq_ready = 1'b1;
    tick();
    chk("ej_req", 32'(mem_req), 32'd1);
    chk("ej_addr300", mem_addr, 32'h300);

    // Flush during FETCH, stale return dropped
    flush = 1'b1; flush_pc = 32'h200;
    tick();
    chk("fl_drain_no_req", 32'(mem_req), 32'd0);
    tick();
    chk("fl_drain_wait", 32'(mem_req), 32'd0);
    mem_done = 1'b1; mem_instr = 32'hDEAD_BEEF;
    tick();
    chk("fl_no_ask", 32'(pred_ask), 32'd0);
    chk("fl_addr200", mem_addr, 32'h200);

    // rdy=0 freezes everything, inputs ignored
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_done = 1'b1; flush = 1'b1; flush_pc = 32'h999; pred_enable = 1'b1;
      tick();
      chk("frz_req", 32'(mem_req), 32'd1);
      chk("frz_addr", mem_addr, 32'h200);
      chk("frz_ask", 32'(pred_ask), 32'd0);
      chk("frz_valid", 32'(iq_valid), 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("frz_after", mem_addr, 32'h200);

    // Asynchronous reset mid-push
    fetch_one(32'h0000_0013, 1'b1, 32'h204, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(iq_valid), 32'd0);
    chk("arst_iq_pc", iq_pc, 32'h0);
    chk("arst_iq_taken", 32'(iq_pred_taken), 32'd0);
    chk("arst_req", 32'(mem_req), 32'd0);
    tick();
    rst = 1'b1;
    wait_fetch();
    chk("arst_restart", mem_addr, 32'h0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rdy          = ($urandom_range(9) != 0);
      iq_ready     = ($urandom_range(9) < 6);
      mem_instr    = $urandom;
      pred_next_pc = $urandom & 32'hFFFF_FFFC;
      pred_taken   = 1'($urandom_range(1));
      flush_pc     = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(39) == 0) flush = 1'b1;
      case (stg)
        S_FET, S_DRN: mem_done = ($urandom_range(9) < 4);
        S_WPR: if ($urandom_range(1) == 1) begin
          pred_enable = 1'b1;
          pred_stall  = ($urandom_range(3) == 0);
        end
        S_PSH: if (m_jw && !m_pend && $urandom_range(3) == 0) begin
          pred_enable = 1'b1;
          iq_ready    = 1'b0;
        end
        S_JW: begin
          int r;
          r = int'($urandom_range(9));
          if (r < 3)      pred_enable = 1'b1;
          else if (r < 5) begin pred_enable = 1'b1; pred_stall = 1'b1; end
        end
        default: ;
      endcase
      tick();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
